serial_addsub_ctrl: RTL
=======================

// Module: serial_addsub_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer that time-shares a single 1-bit fulladder slice.
//  Computes one WIDTH-bit sum or difference in WIDTH cycles.
//  Small-area alternative to the parallel 16-bit subtractor, for non-critical arithmetic.
//  Request side and result side each use a valid/ready handshake.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; legal values >= 2
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start_valid  in   1      request valid
//  start_ready  out  1      controller can accept a request
//  op           in   1      0 = add, 1 = subtract (a - b)
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  res_valid    out  1      result valid
//  res_ready    in   1      consumer accepts result
//  result       out  WIDTH  sum or difference
//  carry_out    out  1      add: carry out; sub: 1 = no borrow (a >= b, unsigned)
//  busy         out  1      high in RUN or DONE
//  ovf          out  1      signed overflow; port exists only with SERIAL_ADDSUB_OVF_EN
// BEHAVIOUR
//  Reset: state=IDLE, result=0, carry_out=0, res_valid=0, busy=0, ovf=0; start_ready=1.
//  FSM states IDLE, RUN, DONE. Outputs are decoded from state and registers only.
//  IDLE:
//   - start_ready=1.
//   - On start_valid & start_ready: latch a, latch (op ? ~b : b), carry<=op, bit count<=0, go RUN.
//  RUN:
//   - Each cycle, drive the slice with a_sh[0], b_sh[0], carry.
//   - Sum bit shifts into result from the MSB side; a_sh and b_sh shift right.
//   - Carry register <= slice cout; bit count increments.
//   - When bit count == WIDTH-1: take the final cout as carry_out, go DONE.
//  DONE:
//   - res_valid=1; result and carry_out are held stable.
//   - On res_ready: go IDLE next edge.
//  Latency: res_valid rises exactly WIDTH cycles after the accepting edge.
//  Throughput: one op per WIDTH+2 cycles; one IDLE cycle is mandatory between ops.
//  Back-to-back: start_valid during RUN or DONE is ignored (start_ready=0); the requester holds.
//  Operand or op changes after acceptance have no effect.
//  Subtraction wraps modulo 2^WIDTH; no saturation.
//  Reset mid-RUN or mid-DONE: op is discarded, FSM returns to IDLE, no res_valid pulse.
//  res_ready while not in DONE: ignored.
//  Count register width: $clog2(WIDTH); the terminal compare handles non-power-of-2 WIDTH.
// CONFIGURATION
//  SERIAL_ADDSUB_OVF_EN defined:
//   - ovf port exists; ovf = carry-in XOR carry-out of the MSB slice.
//   - ovf is registered on the last RUN cycle and valid with res_valid.
//  Undefined: no ovf port; no MSB carry-in capture logic.
// STRUCTURE
//  Package serial_addsub_pkg:
//   - state_t enum {IDLE, RUN, DONE}.
//   - Constants OP_ADD=1'b0, OP_SUB=1'b1.
//  Sub-module: one instance of the existing fulladder as the shared 1-bit slice.
//   - Mapping: x=a_sh[0], y=b_sh[0], cin=carry, A=sum bit.
//  Shifting, FSM and count all live in this module.
// TESTING
//  1 rst, add 16'h0003 + 16'h0005 -> res_valid at accept+16 cycles, result=16'h0008, carry_out=0.
//  2 add 16'hFFFF + 16'h0001 -> result=16'h0000, carry_out=1, ovf=0.
//  3 sub 16'h0005 - 16'h0007 -> result=16'hFFFE, carry_out=0 (borrow).
//  4 add 16'h7FFF + 16'h0001 -> result=16'h8000; ovf=1 with macro; no ovf port without macro.
//  5 res_ready low 5 cycles in DONE -> result/res_valid stable, start_ready=0, new start ignored.
//  6 rst pulse in RUN bit 7 -> no res_valid; start_ready=1 after rst; next op 16'h1234-16'h0234=16'h1000.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

    // Controller phases: waiting for a request, shifting bits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow of a two's-complement add: carry into MSB differs from carry out.
    function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_fulladder.sv
// Single-bit full adder slice time-shared by the serial sequencer.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic A,
    output logic cout
);

    assign A    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one WIDTH-bit result in WIDTH cycles
// using a single shared full adder slice, valid/ready on both sides.
// Optional macro SERIAL_ADDSUB_OVF_EN adds the signed-overflow output ovf.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sum_s;
    logic               cout_s;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    fulladder u_slice (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .A    (sum_s),
        .cout (cout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operand shifters, carry, bit counter and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            cnt_q       <= CNT_ZERO;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            cnt_q       <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update; subtraction is a + ~b + 1 with the +1 as carry-in.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        result_d    = result_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        cnt_d       = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = (op == OP_SUB) ? ~b : b;
                    carry_d = (op == OP_SUB);
                    cnt_d   = CNT_ZERO;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                result_d = {sum_s, result_q[WIDTH-1:1]};
                carry_d  = cout_s;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    carry_out_d = cout_s;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d       = signed_ovf(carry_q, cout_s);
`endif
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign carry_out   = carry_out_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule
